dmem_ctrl: RTL and testbench

//   MIPS data memory with a valid/ready request port and a valid/ready response port.
//   - Word array with byte lanes; supports LB/LBU/LH/LHU/LW and SB/SH/SW.
//   - Programmable wait states; detects misaligned accesses.
//   - Sits between the MEM stage / LSU and the data store; replaces the fixed single-cycle data RAM.

---
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU and the data memory controller.
// The master (LSU) drives requests and accepts responses; the slave serves them.
interface dmem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_misaligned;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned
    );
endinterface

// File: rtl/dmem_ctrl.sv
// MIPS data memory controller: byte-lane word array behind a valid/ready request
// port and a valid/ready response port, with programmable wait states and
// misalignment rejection. Optional saturating error counter on err_cnt when
// DMEM_ERR_CNT_EN is defined.
module dmem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
`ifdef DMEM_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);
    localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;

    logic [31:0] mem_q [Depth];

    logic                  req_mis;
    logic                  accept;
    logic                  access;
    logic                  mem_we;
    logic [ADDR_WIDTH-3:0] widx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;

    // Alignment check on the live request; size 11 is always rejected.
    always_comb begin
        unique case (bus.req_size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = bus.req_addr[0];
            2'b10:   req_mis = (bus.req_addr[1:0] != 2'b00);
            default: req_mis = 1'b1;
        endcase
    end

    assign accept = bus.req_valid && (state_q == StIdle);
    assign access = (state_q == StBusy) && (cnt_q == 4'd0);
    // Gating with rst_n keeps an aborted store from ever reaching the array.
    assign mem_we = rst_n && access && we_q;
    assign widx   = addr_q[ADDR_WIDTH-1:2];
    assign lane   = addr_q[1:0];

    // Lane enables and lane-replicated store data for the captured request.
    always_comb begin
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // Load extraction: right-justify the selected lanes, then extend.
    always_comb begin
        rd_word = mem_q[widx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b01:   load_val = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Byte-lane array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    // Next-state and response data for the IDLE -> BUSY -> RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    mis_d    = req_mis;
                    state_d  = req_mis ? StResp : StBusy;
                    cnt_d    = 4'(WAIT_CYCLES);
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = we_q ? 32'h0 : load_val;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured-request registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.req_ready      = (state_q == StIdle);
    assign bus.rsp_valid      = (state_q == StResp);
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_misaligned = mis_q;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of accepted misaligned requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept && req_mis && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (no wait states and three wait states)
// driven by directed transactions, checked every cycle against a byte-array model.
module tb_dmem_ctrl;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_we, req_signed, rsp_ready;
    logic [1:0]  req_size  [2];
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  req_ready, rsp_valid, rsp_mis;
    logic [31:0] rsp_rdata [2];

    dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus0 ();
    dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus1 ();

    assign bus0.req_valid  = req_valid[0];
    assign bus0.req_we     = req_we[0];
    assign bus0.req_size   = req_size[0];
    assign bus0.req_signed = req_signed[0];
    assign bus0.req_addr   = req_addr[0];
    assign bus0.req_wdata  = req_wdata[0];
    assign bus0.rsp_ready  = rsp_ready[0];
    assign req_ready[0]    = bus0.req_ready;
    assign rsp_valid[0]    = bus0.rsp_valid;
    assign rsp_rdata[0]    = bus0.rsp_rdata;
    assign rsp_mis[0]      = bus0.rsp_misaligned;

    assign bus1.req_valid  = req_valid[1];
    assign bus1.req_we     = req_we[1];
    assign bus1.req_size   = req_size[1];
    assign bus1.req_signed = req_signed[1];
    assign bus1.req_addr   = req_addr[1];
    assign bus1.req_wdata  = req_wdata[1];
    assign bus1.rsp_ready  = rsp_ready[1];
    assign req_ready[1]    = bus1.req_ready;
    assign rsp_valid[1]    = bus1.rsp_valid;
    assign rsp_rdata[1]    = bus1.rsp_rdata;
    assign rsp_mis[1]      = bus1.rsp_misaligned;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_cnt0, err_cnt1;
`endif

    dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef DMEM_ERR_CNT_EN
        ,
        .err_cnt (err_cnt0)
`endif
    );

    dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef DMEM_ERR_CNT_EN
        ,
        .err_cnt (err_cnt1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no DUT response within bound at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mdl_mem [2][4096];

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit mdl_mis(input logic [1:0] size, input logic [11:0] addr);
        int a = int'(addr);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input int d, input logic [1:0] size, input bit sgn,
                                             input logic [11:0] addr);
        int nb = nbytes(size);
        logic [31:0] v = 32'h0;
        logic [31:0] mask;
        for (int i = 0; i < nb; i++) v = v | (32'(mdl_mem[d][int'(addr) + i]) << (8 * i));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (sgn && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    bit          pend    [2];
    int          rise_at [2];
    bit          t_we    [2];
    logic [1:0]  t_size  [2];
    bit          t_sgn   [2];
    logic [11:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    bit          t_mis   [2];
    logic [31:0] e_rdata [2];
    int          ncyc = 0;

    // Per-cycle compare of both DUTs against the transaction model.
    always @(negedge clk) begin
        ncyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend[d] = 1'b0;
            end else if (!pend[d]) begin
                chk("idle_req_ready", 32'(req_ready[d]), 32'd1);
                chk("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);
                if (req_valid[d] && req_ready[d]) begin
                    pend[d]    = 1'b1;
                    t_we[d]    = req_we[d];
                    t_size[d]  = req_size[d];
                    t_sgn[d]   = req_signed[d];
                    t_addr[d]  = req_addr[d];
                    t_wdata[d] = req_wdata[d];
                    t_mis[d]   = mdl_mis(req_size[d], req_addr[d]);
                    rise_at[d] = t_mis[d] ? ncyc + 1 : ncyc + 2 + int'(wait_of(d));
                end
            end else if (ncyc < rise_at[d]) begin
                chk("busy_req_ready", 32'(req_ready[d]), 32'd0);
                chk("busy_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            end else begin
                if (ncyc == rise_at[d]) begin
                    if (t_mis[d] || t_we[d]) e_rdata[d] = 32'h0;
                    else e_rdata[d] = mdl_load(d, t_size[d], t_sgn[d], t_addr[d]);
                    if (!t_mis[d] && t_we[d]) begin
                        for (int i = 0; i < nbytes(t_size[d]); i++)
                            mdl_mem[d][int'(t_addr[d]) + i] = 8'(t_wdata[d] >> (8 * i));
                    end
                end
                chk("resp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
                chk("resp_req_ready", 32'(req_ready[d]), 32'd0);
                chk("resp_rdata", rsp_rdata[d], e_rdata[d]);
                chk("resp_misaligned", 32'(rsp_mis[d]), 32'(t_mis[d]));
                if (rsp_ready[d]) pend[d] = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One transaction; lat counts edges from the acceptance edge to rsp_valid.
    task automatic do_req(input int d, input bit we, input logic [1:0] size, input bit sgn,
                          input logic [11:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output bit mis, output int lat);
        int k;
        @(posedge clk);
        #1;
        req_we[d]     = we;
        req_size[d]   = size;
        req_signed[d] = sgn;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_valid[d]  = 1'b1;
        rsp_ready[d]  = (hold == 0);
        k = 0;
        @(negedge clk);
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[d]) timeout("accept");
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) timeout("rsp_valid");
        rd  = rsp_rdata[d];
        mis = rsp_mis[d];
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready[d] = 1'b1;
        end
        k = 0;
        while (!(rsp_valid[d] && rsp_ready[d]) && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          mis;
        int          lat;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_signed[d] = 1'b0; rsp_ready[d] = 1'b1;
            req_size[d] = 2'd0;  req_addr[d] = '0;  req_wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'h0);
            chk("rst_misaligned", 32'(rsp_mis[d]), 32'd0);
        end

        // Word round trip, no wait states
        do_req(0, 1, 2'd2, 0, 12'h010, 32'hDEADBEEF, 0, rd, mis, lat);
        chk("t1_sw_rdata", rd, 32'h0);
        chk("t1_sw_lat", 32'(lat), 32'd1);
        do_req(0, 0, 2'd2, 0, 12'h010, 32'h0, 0, rd, mis, lat);
        chk("t1_lw_rdata", rd, 32'hDEADBEEF);
        chk("t1_lw_lat", 32'(lat), 32'd1);

        // Byte lanes
        do_req(0, 1, 2'd2, 0, 12'h020, 32'h00000000, 0, rd, mis, lat);
        do_req(0, 1, 2'd0, 0, 12'h023, 32'hFFFFFF80, 0, rd, mis, lat);
        do_req(0, 0, 2'd2, 0, 12'h020, 32'h0, 0, rd, mis, lat);
        chk("t2_lw", rd, 32'h80000000);
        do_req(0, 0, 2'd0, 1, 12'h023, 32'h0, 0, rd, mis, lat);
        chk("t2_lb", rd, 32'hFFFFFF80);
        do_req(0, 0, 2'd0, 0, 12'h023, 32'h0, 0, rd, mis, lat);
        chk("t2_lbu", rd, 32'h00000080);
        do_req(0, 1, 2'd0, 0, 12'h021, 32'h0000007F, 0, rd, mis, lat);
        do_req(0, 0, 2'd0, 1, 12'h021, 32'h0, 0, rd, mis, lat);
        chk("t2_lb_pos", rd, 32'h0000007F);

        // Halfword
        do_req(0, 1, 2'd2, 0, 12'h030, 32'h11223344, 0, rd, mis, lat);
        do_req(0, 1, 2'd1, 0, 12'h032, 32'h00008001, 0, rd, mis, lat);
        do_req(0, 0, 2'd2, 1, 12'h030, 32'h0, 0, rd, mis, lat);
        chk("t3_lw", rd, 32'h80013344);
        do_req(0, 0, 2'd1, 1, 12'h032, 32'h0, 0, rd, mis, lat);
        chk("t3_lh", rd, 32'hFFFF8001);
        do_req(0, 0, 2'd1, 1, 12'h030, 32'h0, 0, rd, mis, lat);
        chk("t3_lh_low", rd, 32'h00003344);

        // Misaligned
        do_req(0, 1, 2'd2, 0, 12'h040, 32'hCAFEF00D, 0, rd, mis, lat);
        do_req(0, 1, 2'd2, 0, 12'h041, 32'hFFFFFFFF, 0, rd, mis, lat);
        chk("t4_sw_mis", 32'(mis), 32'd1);
        chk("t4_sw_mis_lat", 32'(lat), 32'd0);
        do_req(0, 0, 2'd1, 1, 12'h043, 32'h0, 0, rd, mis, lat);
        chk("t4_lh_mis", 32'(mis), 32'd1);
        chk("t4_lh_rdata", rd, 32'h0);
        do_req(0, 0, 2'd2, 0, 12'h040, 32'h0, 0, rd, mis, lat);
        chk("t4_word_kept", rd, 32'hCAFEF00D);
`ifdef DMEM_ERR_CNT_EN
        chk("t4_err_cnt", 32'(err_cnt0), 32'd2);
`endif

        // Wait states and backpressure
        do_req(1, 1, 2'd2, 0, 12'h060, 32'h0BADF00D, 0, rd, mis, lat);
        chk("t5_sw_lat", 32'(lat), 32'd4);
        do_req(1, 0, 2'd2, 1, 12'h060, 32'h0, 5, rd, mis, lat);
        chk("t5_lw_rdata", rd, 32'h0BADF00D);
        chk("t5_lw_lat", 32'(lat), 32'd4);
        do_req(1, 0, 2'd3, 0, 12'h064, 32'h0, 0, rd, mis, lat);
        chk("t5_size3_mis", 32'(mis), 32'd1);
        do_req(1, 0, 2'd0, 0, 12'h062, 32'h0, 0, rd, mis, lat);
        chk("t5_lbu", rd, 32'h000000AD);

        // Reset in the middle of a pending store
        do_req(1, 1, 2'd2, 0, 12'h050, 32'hA5A5A5A5, 0, rd, mis, lat);
        @(posedge clk);
        #1;
        req_we[1] = 1'b1; req_size[1] = 2'd2; req_signed[1] = 1'b0;
        req_addr[1] = 12'h050; req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        @(negedge clk);
        chk("t6_accept_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("t6_req_ready", 32'(req_ready[1]), 32'd1);
        do_req(1, 0, 2'd2, 0, 12'h050, 32'h0, 0, rd, mis, lat);
        chk("t6_old_value", rd, 32'hA5A5A5A5);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
